// File: rtl/lcd_status_display.sv
// Write-only HD44780 16x2 driver: power-up wait, init sequence, then periodic
// two-line refresh rendered from a single snapshot of the game status inputs.
module lcd_status_display #(
   parameter int CLK_HZ      = 25000000,
   parameter int PWR_WAIT    = 500000,
   parameter int SETUP_CYC   = 2,
   parameter int EN_HIGH_CYC = 12,
   parameter int CMD_WAIT    = 1250,
   parameter int CLEAR_WAIT  = 50000,
   parameter int REFRESH_CYC = 2500000
) (
   input  logic        clk_25MHz,
   input  logic        reset_n,
   input  logic [1:0]  lcd_state,
   input  logic [6:0]  score_in,
   input  logic [31:0] game_timer,
   output logic [7:0]  LCD_DATA,
   output logic        LCD_RS,
   output logic        LCD_RW,
   output logic        LCD_EN,
   output logic        LCD_ON,
   output logic        LCD_BLON,
   output logic        init_done
);

   typedef enum logic [3:0] {
      S_PWR_WAIT, S_INIT, S_SNAP, S_DIV, S_BCD,
      S_ADDR1, S_LINE1, S_ADDR2, S_LINE2, S_REFRESH
   } state_t;

   typedef enum logic [1:0] {W_SETUP, W_EN, W_WAIT} wr_phase_t;

   localparam logic [31:0] PWR_LAST     = 32'(PWR_WAIT - 1);
   localparam logic [31:0] SETUP_LAST   = 32'(SETUP_CYC - 1);
   localparam logic [31:0] EN_LAST      = 32'(EN_HIGH_CYC - 1);
   localparam logic [31:0] CMD_LAST     = 32'(CMD_WAIT - 1);
   localparam logic [31:0] CLEAR_LAST   = 32'(CLEAR_WAIT - 1);
   localparam logic [31:0] REFRESH_LAST = 32'(REFRESH_CYC - 1);
   localparam logic [32:0] DIVISOR      = 33'(CLK_HZ);

   state_t      state, state_nx;
   wr_phase_t   phase, phase_nx;
   logic [31:0] cnt, cnt_nx;
   logic [3:0]  idx, idx_nx;

   logic [1:0]  st_snap;
   logic [31:0] div_rem, div_q, div_rem_nx, div_q_nx;
   logic [32:0] rem_shift;
   logic [11:0] sec_bcd, sec_adj;
   logic [7:0]  sec_sh;
   logic [7:0]  sc_bcd, sc_adj;
   logic [7:0]  sc_sh;

   logic        wr_state, wr_rs, wr_done;
   logic [7:0]  wr_byte;
   logic [31:0] wait_last;
   logic [7:0]  data_d;
   logic        rs_d, en_d, init_done_d;

   function automatic logic [3:0] dd_adj(input logic [3:0] d);
      return (d >= 4'd5) ? d + 4'd3 : d;
   endfunction

   function automatic logic [7:0] line1_char(input logic [1:0] st, input logic [3:0] i);
      logic [7:0] c;
      c = 8'h20;
      if (!st[1]) begin
         case (i)
            4'd0:    c = "G";
            4'd1:    c = "A";
            4'd2:    c = "M";
            4'd3:    c = "E";
            4'd5:    c = st[0] ? "O" : "S";
            4'd6:    c = st[0] ? "V" : "T";
            4'd7:    c = st[0] ? "E" : "A";
            4'd8:    c = "R";
            4'd9:    c = st[0] ? " " : "T";
            default: c = 8'h20;
         endcase
      end
      return c;
   endfunction

   assign LCD_RW   = 1'b0;
   assign LCD_ON   = 1'b1;
   assign LCD_BLON = 1'b1;

   // One restoring-division step: remainder stays below CLK_HZ, so 32 bits hold it.
   always_comb begin
      rem_shift = {div_rem, div_q[31]};
      if (rem_shift >= DIVISOR) begin
         div_rem_nx = 32'(rem_shift - DIVISOR);
         div_q_nx   = {div_q[30:0], 1'b1};
      end else begin
         div_rem_nx = rem_shift[31:0];
         div_q_nx   = {div_q[30:0], 1'b0};
      end
      sec_adj = {dd_adj(sec_bcd[11:8]), dd_adj(sec_bcd[7:4]), dd_adj(sec_bcd[3:0])};
      sc_adj  = {dd_adj(sc_bcd[7:4]), dd_adj(sc_bcd[3:0])};
   end

   always_comb begin
      wr_state = 1'b0;
      wr_rs    = 1'b0;
      wr_byte  = 8'h00;
      case (state)
         S_INIT: begin
            wr_state = 1'b1;
            case (idx[1:0])
               2'd0:    wr_byte = 8'h38;
               2'd1:    wr_byte = 8'h0C;
               2'd2:    wr_byte = 8'h01;
               default: wr_byte = 8'h06;
            endcase
         end
         S_ADDR1: begin
            wr_state = 1'b1;
            wr_byte  = 8'h80;
         end
         S_ADDR2: begin
            wr_state = 1'b1;
            wr_byte  = 8'hC0;
         end
         S_LINE1: begin
            wr_state = 1'b1;
            wr_rs    = 1'b1;
            wr_byte  = line1_char(st_snap, idx);
         end
         S_LINE2: begin
            wr_state = 1'b1;
            wr_rs    = 1'b1;
            case (idx)
               4'd0:    wr_byte = "S";
               4'd1:    wr_byte = "C";
               4'd2:    wr_byte = "O";
               4'd3:    wr_byte = "R";
               4'd4:    wr_byte = "E";
               4'd6:    wr_byte = {4'h3, sc_bcd[7:4]};
               4'd7:    wr_byte = {4'h3, sc_bcd[3:0]};
               4'd10:   wr_byte = "T";
               4'd12:   wr_byte = {4'h3, sec_bcd[11:8]};
               4'd13:   wr_byte = {4'h3, sec_bcd[7:4]};
               4'd14:   wr_byte = {4'h3, sec_bcd[3:0]};
               4'd15:   wr_byte = "s";
               default: wr_byte = 8'h20;
            endcase
         end
         default: ;
      endcase
      wait_last = (!wr_rs && wr_byte == 8'h01) ? CLEAR_LAST : CMD_LAST;
      wr_done   = wr_state && (phase == W_WAIT) && (cnt == wait_last);
   end

   // Next-state logic; every write state shares the SETUP/EN/WAIT sub-sequence.
   always_comb begin
      state_nx = state;
      phase_nx = phase;
      cnt_nx   = cnt + 32'd1;
      idx_nx   = idx;
      case (state)
         S_PWR_WAIT: if (cnt == PWR_LAST) begin
            state_nx = S_INIT;
            cnt_nx   = '0;
         end
         S_SNAP: begin
            state_nx = S_DIV;
            cnt_nx   = '0;
         end
         S_DIV: if (cnt == 32'd31) begin
            state_nx = S_BCD;
            cnt_nx   = '0;
         end
         S_BCD: if (cnt == 32'd7) begin
            state_nx = S_ADDR1;
            phase_nx = W_SETUP;
            idx_nx   = '0;
            cnt_nx   = '0;
         end
         S_REFRESH: if (lcd_state != st_snap || cnt == REFRESH_LAST) begin
            state_nx = S_SNAP;
            cnt_nx   = '0;
         end
         default: begin
            case (phase)
               W_SETUP: if (cnt == SETUP_LAST) begin
                  phase_nx = W_EN;
                  cnt_nx   = '0;
               end
               W_EN: if (cnt == EN_LAST) begin
                  phase_nx = W_WAIT;
                  cnt_nx   = '0;
               end
               default: if (wr_done) begin
                  phase_nx = W_SETUP;
                  cnt_nx   = '0;
                  idx_nx   = idx + 4'd1;
                  case (state)
                     S_INIT: if (idx == 4'd3) begin
                        state_nx = S_SNAP;
                        idx_nx   = '0;
                     end
                     S_ADDR1: begin
                        state_nx = S_LINE1;
                        idx_nx   = '0;
                     end
                     S_LINE1: if (idx == 4'd15) state_nx = S_ADDR2;
                     S_ADDR2: begin
                        state_nx = S_LINE2;
                        idx_nx   = '0;
                     end
                     S_LINE2: if (idx == 4'd15) state_nx = S_REFRESH;
                     default: ;
                  endcase
               end
            endcase
         end
      endcase
   end

   // Pin outputs are registered; RS/DATA keep the last byte outside write states.
   always_comb begin
      data_d      = LCD_DATA;
      rs_d        = LCD_RS;
      en_d        = 1'b0;
      init_done_d = init_done | (state != S_PWR_WAIT && state != S_INIT);
      if (wr_state) begin
         data_d = wr_byte;
         rs_d   = wr_rs;
         en_d   = (phase == W_EN);
      end
   end

   always_ff @(posedge clk_25MHz or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_PWR_WAIT;
         phase     <= W_SETUP;
         cnt       <= '0;
         idx       <= '0;
         LCD_DATA  <= 8'h00;
         LCD_RS    <= 1'b0;
         LCD_EN    <= 1'b0;
         init_done <= 1'b0;
      end else begin
         state     <= state_nx;
         phase     <= phase_nx;
         cnt       <= cnt_nx;
         idx       <= idx_nx;
         LCD_DATA  <= data_d;
         LCD_RS    <= rs_d;
         LCD_EN    <= en_d;
         init_done <= init_done_d;
      end
   end

   always_ff @(posedge clk_25MHz or negedge reset_n) begin
      if (!reset_n) begin
         st_snap <= '0;
         div_rem <= '0;
         div_q   <= '0;
         sec_bcd <= '0;
         sec_sh  <= '0;
         sc_bcd  <= '0;
         sc_sh   <= '0;
      end else begin
         case (state)
            S_SNAP: begin
               st_snap <= lcd_state;
               div_q   <= game_timer;
               div_rem <= '0;
               sc_sh   <= (score_in > 7'd99) ? 8'd99 : {1'b0, score_in};
               sc_bcd  <= '0;
            end
            S_DIV: begin
               div_q   <= div_q_nx;
               div_rem <= div_rem_nx;
               if (cnt == 32'd31) begin
                  sec_sh  <= div_q_nx[7:0];
                  sec_bcd <= '0;
               end
            end
            S_BCD: begin
               {sec_bcd, sec_sh} <= {sec_adj[10:0], sec_sh, 1'b0};
               {sc_bcd, sc_sh}   <= {sc_adj[6:0], sc_sh, 1'b0};
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_status_display.sv
// Bench for lcd_status_display: captures every EN strobe as a byte, checks
// pin timing, and compares the byte stream against a string-level frame model.
module tb_lcd_status_display;

   localparam int HZ = 25000000;
   localparam int PW = 200;
   localparam int S  = 2;
   localparam int E  = 12;
   localparam int W  = 20;
   localparam int CW = 100;
   localparam int R  = 300;

   logic        clk_25MHz = 1'b0;
   logic        reset_n   = 1'b0;
   logic [1:0]  lcd_state = 2'd0;
   logic [6:0]  score_in  = 7'd0;
   logic [31:0] game_timer = 32'd0;
   logic [7:0]  LCD_DATA;
   logic        LCD_RS, LCD_RW, LCD_EN, LCD_ON, LCD_BLON, init_done;

   lcd_status_display #(
      .CLK_HZ(HZ), .PWR_WAIT(PW), .SETUP_CYC(S), .EN_HIGH_CYC(E),
      .CMD_WAIT(W), .CLEAR_WAIT(CW), .REFRESH_CYC(R)
   ) dut (
      .clk_25MHz(clk_25MHz), .reset_n(reset_n), .lcd_state(lcd_state),
      .score_in(score_in), .game_timer(game_timer), .LCD_DATA(LCD_DATA),
      .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN), .LCD_ON(LCD_ON),
      .LCD_BLON(LCD_BLON), .init_done(init_done)
   );

   // ---------------- clock / reset ----------------
   always #20 clk_25MHz = ~clk_25MHz;

   int cyc = 0;
   always @(posedge clk_25MHz) cyc <= cyc + 1;

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- scoreboard / model ----------------
   logic [8:0] exp_q[$];

   task automatic push_init();
      exp_q.push_back(9'h038);
      exp_q.push_back(9'h00C);
      exp_q.push_back(9'h001);
      exp_q.push_back(9'h006);
   endtask

   task automatic push_frame(input logic [1:0] st, input int sc, input logic [31:0] tm);
      string l1, l2;
      longint unsigned t;
      int sat, sec;
      logic [7:0] ch;
      case (st)
         2'd0:    l1 = "GAME START      ";
         2'd1:    l1 = "GAME OVER       ";
         default: l1 = "                ";
      endcase
      t   = tm;
      sat = (sc > 99) ? 99 : sc;
      sec = int'((t / HZ) % 256);
      l2  = $sformatf("SCORE %02d  T %03ds", sat, sec);
      exp_q.push_back({1'b0, 8'h80});
      for (int i = 0; i < 16; i++) begin
         ch = l1[i];
         exp_q.push_back({1'b1, ch});
      end
      exp_q.push_back({1'b0, 8'hC0});
      for (int i = 0; i < 16; i++) begin
         ch = l2[i];
         exp_q.push_back({1'b1, ch});
      end
   endtask

   // ---------------- bus monitor ----------------
   int         cap_cnt = 0;
   int         rise_cyc = 0;
   int         fall_cyc = 0;
   int         en_hi_cnt = 0;
   int         same_cnt = 0;
   int         n_since_rst = 0;
   int         prev_wait = 0;
   logic       prev_en = 1'b0;
   logic       have_prev = 1'b0;
   logic [8:0] last_bus = '0;
   logic [8:0] cur_byte = '0;
   logic [8:0] exp_b;

   always @(negedge clk_25MHz) begin
      if (!reset_n) begin
         prev_en     = 1'b0;
         have_prev   = 1'b0;
         n_since_rst = 0;
         same_cnt    = 0;
         en_hi_cnt   = 0;
         last_bus    = {LCD_RS, LCD_DATA};
      end else begin
         if ({LCD_RS, LCD_DATA} != last_bus) same_cnt = 0;
         else same_cnt++;
         last_bus = {LCD_RS, LCD_DATA};
         if (LCD_EN && !prev_en) begin
            rise_cyc  = cyc;
            cur_byte  = last_bus;
            en_hi_cnt = 1;
            check("setup_cycles", same_cnt >= S, 1'b1);
            if (have_prev) check("write_gap", (cyc - fall_cyc) >= prev_wait + S, 1'b1);
            exp_b = (exp_q.size() != 0) ? exp_q.pop_front() : 9'bx;
            check("byte", cur_byte, exp_b);
            check("init_done_at_byte", init_done, n_since_rst >= 4);
            check("rw_on_blon", {LCD_RW, LCD_ON, LCD_BLON}, 3'b011);
            n_since_rst++;
            cap_cnt++;
         end else if (LCD_EN && prev_en) begin
            en_hi_cnt++;
         end else if (!LCD_EN && prev_en) begin
            check("en_width", en_hi_cnt, E);
            check("bus_hold", same_cnt >= S + E, 1'b1);
            fall_cyc  = cyc;
            have_prev = 1'b1;
            prev_wait = (cur_byte == 9'h001) ? CW : W;
         end
         prev_en = LCD_EN;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_caps(input int target, input int budget);
      int n;
      n = 0;
      while (cap_cnt < target && n < budget) begin
         @(posedge clk_25MHz);
         n++;
      end
      if (cap_cnt < target) check("wait_bytes", cap_cnt, target);
   endtask

   // Waits into REFRESH, applies new inputs, checks when the next frame starts.
   task automatic next_frame(input logic early, input logic [1:0] st, input int sc,
                             input logic [31:0] tm, inout int base);
      int t_end, t_chg, d;
      t_end = rise_cyc;
      repeat (E + W + 20) @(negedge clk_25MHz);
      if (early) lcd_state = st;
      score_in   = 7'(sc);
      game_timer = tm;
      t_chg      = cyc;
      push_frame(lcd_state, sc, tm);
      wait_caps(base + 1, R + 300);
      if (early) begin
         d = rise_cyc - t_chg;
         check("early_snap_latency", d >= 36 + S && d <= 51 + S, 1'b1);
      end else begin
         d = rise_cyc - t_end;
         check("refresh_gap", d >= S + E + W + R + 34 && d <= S + E + W + R + 49, 1'b1);
      end
      base += 34;
      wait_caps(base, 3000);
   endtask

   // ---------------- main sequence ----------------
   int base, t_rel, sc;
   logic [1:0] st;
   logic [31:0] tm;

   initial begin
      repeat (5) @(negedge clk_25MHz);
      check("rst_data", LCD_DATA, 8'h00);
      check("rst_rs", LCD_RS, 1'b0);
      check("rst_rw", LCD_RW, 1'b0);
      check("rst_en", LCD_EN, 1'b0);
      check("rst_on", LCD_ON, 1'b1);
      check("rst_blon", LCD_BLON, 1'b1);
      check("rst_init_done", init_done, 1'b0);

      push_init();
      push_frame(2'd0, 0, 32'd0);
      reset_n = 1'b1;
      t_rel   = cyc;
      wait_caps(1, PW + 100);
      check("pwr_wait", (rise_cyc - t_rel) >= PW && (rise_cyc - t_rel) <= PW + S + 2, 1'b1);
      base = 38;
      wait_caps(base, 5000);

      // Fixed timer/score patterns, then a mid-refresh lcd_state change.
      next_frame(1'b0, 2'd0, 7, 32'd25000000 * 32'd123 + 32'd5, base);
      next_frame(1'b0, 2'd0, 120, 32'hFFFF_FFFF, base);
      next_frame(1'b1, 2'd1, 120, 32'hFFFF_FFFF, base);

      for (int f = 0; f < 6; f++) begin
         st = lcd_state + 2'($urandom_range(1, 3));
         sc = $urandom_range(0, 127);
         tm = $urandom();
         next_frame(1'($urandom_range(0, 1)), st, sc, tm, base);
      end

      // Reset in the middle of a line-2 EN pulse.
      push_frame(lcd_state, int'(score_in), game_timer);
      wait_caps(base + 21, R + 1500);
      repeat (5) @(negedge clk_25MHz);
      #2 reset_n = 1'b0;
      #1;
      check("midrst_en", LCD_EN, 1'b0);
      check("midrst_init_done", init_done, 1'b0);
      check("midrst_data", LCD_DATA, 8'h00);
      exp_q.delete();
      repeat (3) @(negedge clk_25MHz);
      push_init();
      push_frame(lcd_state, int'(score_in), game_timer);
      base    = cap_cnt + 38;
      reset_n = 1'b1;
      t_rel   = cyc;
      wait_caps(base - 37, PW + 100);
      check("pwr_wait_again", (rise_cyc - t_rel) >= PW && (rise_cyc - t_rel) <= PW + S + 2, 1'b1);
      wait_caps(base, 5000);
      repeat (W + 5) @(negedge clk_25MHz);
      check("exp_queue_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
